// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NREQ requesters.
// Optional requester locking is compiled in with `define RF_ARB_LOCK_EN.
module rf_write_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] addr_i,
    input  logic [NREQ*DW-1:0] data_i,
    output logic [NREQ-1:0]    gnt,
    output logic               rf_we,
    output logic [AW-1:0]      rf_a3,
    output logic [DW-1:0]      rf_wd3,
    output logic               busy
`ifdef RF_ARB_LOCK_EN
    ,
    input  logic [NREQ-1:0]    lock_i
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_a3_q, rf_a3_d;
    logic [DW-1:0] rf_wd3_q, rf_wd3_d;
`ifdef RF_ARB_LOCK_EN
    logic [PW-1:0] owner_q, owner_d;
`endif

    logic          hi_vld, lo_vld;
    logic [PW-1:0] hi_idx, lo_idx;
    logic          win_vld;
    logic [PW-1:0] win;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;

    // Lowest set request at or above the pointer, else lowest set request overall.
    always_comb begin
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_vld = 1'b1;
                lo_idx = PW'(i);
                if (i >= int'(rr_ptr_q)) begin
                    hi_vld = 1'b1;
                    hi_idx = PW'(i);
                end
            end
        end
    end

    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        gnt     = '0;
        if (rst && !hold) begin
            if (state_q == IDLE) begin
                win_vld = hi_vld | lo_vld;
                win     = hi_vld ? hi_idx : lo_idx;
            end
`ifdef RF_ARB_LOCK_EN
            else if (req[owner_q]) begin
                win_vld = 1'b1;
                win     = owner_q;
            end
`endif
        end
        if (win_vld) begin
            gnt[win] = 1'b1;
        end
    end

    assign busy = rst & (|req) & ~(|gnt);

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                win_addr = addr_i[i*AW +: AW];
                win_data = data_i[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        rf_we_d  = 1'b0;
        rf_a3_d  = rf_a3_q;
        rf_wd3_d = rf_wd3_q;
`ifdef RF_ARB_LOCK_EN
        owner_d  = owner_q;
`endif
        if (win_vld) begin
            // Register 0 is hardwired to zero: the transfer completes but never reaches the file.
            if (win_addr != '0) begin
                rf_we_d  = 1'b1;
                rf_a3_d  = win_addr;
                rf_wd3_d = win_data;
            end
`ifdef RF_ARB_LOCK_EN
            if (lock_i[win]) begin
                state_d = LOCKED;
                owner_d = win;
            end else begin
                state_d  = IDLE;
                rr_ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
            end
`else
            rr_ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            rf_we_q  <= 1'b0;
            rf_a3_q  <= '0;
            rf_wd3_q <= '0;
`ifdef RF_ARB_LOCK_EN
            owner_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            rf_we_q  <= rf_we_d;
            rf_a3_q  <= rf_a3_d;
            rf_wd3_q <= rf_wd3_d;
`ifdef RF_ARB_LOCK_EN
            owner_q  <= owner_d;
`endif
        end
    end

    assign rf_we  = rf_we_q;
    assign rf_a3  = rf_a3_q;
    assign rf_wd3 = rf_wd3_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: stimulus queues expected grants/writes, a negedge monitor checks them.
// Exercises the lock sequence as well when RF_ARB_LOCK_EN is defined.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic [3:0]  req;
    logic [11:0] addr_i;
    logic [31:0] data_i;
    logic [3:0]  gnt;
    logic        rf_we;
    logic [2:0]  rf_a3;
    logic [7:0]  rf_wd3;
    logic        busy;
`ifdef RF_ARB_LOCK_EN
    logic [3:0]  lock_i;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0]  gnt_exp_q[$];
    logic [10:0] wr_exp_q[$];

    rf_write_arbiter #(.NREQ(4), .DW(8), .AW(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .hold   (hold),
        .req    (req),
        .addr_i (addr_i),
        .data_i (data_i),
        .gnt    (gnt),
        .rf_we  (rf_we),
        .rf_a3  (rf_a3),
        .rf_wd3 (rf_wd3),
        .busy   (busy)
`ifdef RF_ARB_LOCK_EN
        ,
        .lock_i (lock_i)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s value=%0h at %0t", name, act, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int w, input logic [2:0] a, input logic [7:0] d);
        addr_i[w*3 +: 3] = a;
        data_i[w*8 +: 8] = d;
    endtask

    task automatic expect_xfer(input int w, input logic [2:0] a, input logic [7:0] d);
        gnt_exp_q.push_back(4'b0001 << w);
        if (a != 3'd0) wr_exp_q.push_back({a, d});
    endtask

    // Monitor: any grant or write the DUT presents must match the head of its queue.
    always @(negedge clk) begin
        if (gnt !== 4'b0000) begin
            if (gnt_exp_q.size() == 0) chk("unexpected_gnt", {28'd0, gnt}, 32'd0);
            else                       chk("gnt", {28'd0, gnt}, {28'd0, gnt_exp_q.pop_front()});
        end
        if (rf_we !== 1'b0) begin
            if (wr_exp_q.size() == 0) chk("unexpected_write", {21'd0, rf_a3, rf_wd3}, 32'd0);
            else                      chk("write", {21'd0, rf_a3, rf_wd3}, {21'd0, wr_exp_q.pop_front()});
        end
    end

    initial begin
        rst    = 1'b0;
        hold   = 1'b0;
        req    = 4'b0000;
        addr_i = '0;
        data_i = '0;
`ifdef RF_ARB_LOCK_EN
        lock_i = 4'b0000;
`endif
        #2 req = 4'b1111;
        #1;
        chk("reset_we",   {31'd0, rf_we}, 32'd0);
        chk("reset_a3",   {29'd0, rf_a3}, 32'd0);
        chk("reset_wd3",  {24'd0, rf_wd3}, 32'd0);
        chk("reset_gnt",  {28'd0, gnt}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        req = 4'b0000;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();

        // All four requesting: pointer starts at 0, strict rotation, one write per grant.
        for (int w = 0; w < 4; w++) set_src(w, 3'(w + 1), 8'h40);
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            set_src(i % 4, 3'((i % 4) + 1), 8'(8'h40 + i));
            expect_xfer(i % 4, 3'((i % 4) + 1), 8'(8'h40 + i));
            cyc();
        end
        req = 4'b0000;
        cyc();

        // Single requester 0: one-cycle write latency, then write port idles.
        set_src(0, 3'd5, 8'hA5);
        req = 4'b0001;
        expect_xfer(0, 3'd5, 8'hA5);
        #1 chk("t1_busy", {31'd0, busy}, 32'd0);
        cyc();
        req = 4'b0000;
        chk("t1_we_high", {31'd0, rf_we}, 32'd1);
        cyc();
        chk("t1_we_low", {31'd0, rf_we}, 32'd0);

        // Address 0 from requester 2 (pointer 1): granted, no write, pointer moves to 3.
        set_src(2, 3'd0, 8'hFF);
        req = 4'b0100;
        expect_xfer(2, 3'd0, 8'hFF);
        cyc();
        req = 4'b0000;
        chk("t4_we",  {31'd0, rf_we}, 32'd0);
        chk("t4_wd3", {24'd0, rf_wd3}, 32'hA5);
        chk("t4_a3",  {29'd0, rf_a3}, 32'd5);
        set_src(0, 3'd1, 8'hA5);
        set_src(1, 3'd2, 8'h11);
        set_src(2, 3'd3, 8'h22);
        set_src(3, 3'd4, 8'h77);
        req = 4'b1111;
        expect_xfer(3, 3'd4, 8'h77);
        cyc();
        req = 4'b0000;
        cyc();

        // Hold suppresses grants while requests wait; pointer is 0 afterwards.
        req  = 4'b0110;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_hold_gnt",  {28'd0, gnt}, 32'd0);
            chk("t3_hold_busy", {31'd0, busy}, 32'd1);
            chk("t3_hold_we",   {31'd0, rf_we}, 32'd0);
            cyc();
        end
        hold = 1'b0;
        expect_xfer(1, 3'd2, 8'h11);
        cyc();
        req = 4'b0100;
        expect_xfer(2, 3'd3, 8'h22);
        cyc();
        req = 4'b0000;
        cyc();

        // Reset right after a grant to requester 1: the pending write is dropped.
        req = 4'b0010;
        expect_xfer(1, 3'd0, 8'h00);
        cyc();
        rst = 1'b0;
        req = 4'b0000;
        #1;
        chk("t5_we",  {31'd0, rf_we}, 32'd0);
        chk("t5_a3",  {29'd0, rf_a3}, 32'd0);
        chk("t5_wd3", {24'd0, rf_wd3}, 32'd0);
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        cyc();
        req = 4'b1111;
        expect_xfer(0, 3'd1, 8'hA5);
        cyc();
        req = 4'b0000;
        cyc();

`ifdef RF_ARB_LOCK_EN
        // Requester 1 (pointer 1) locks for three transfers, unlocks on the fourth; then 3, then 0.
        set_src(3, 3'd4, 8'h33);
        req = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            set_src(1, 3'd6, 8'(8'h61 + k));
            lock_i = (k < 3) ? 4'b0010 : 4'b0000;
            expect_xfer(1, 3'd6, 8'(8'h61 + k));
            cyc();
            if (k == 1) begin
                req = 4'b1001;
                #1;
                chk("t6_owner_idle_gnt",  {28'd0, gnt}, 32'd0);
                chk("t6_owner_idle_busy", {31'd0, busy}, 32'd1);
                cyc();
                req = 4'b1011;
            end
        end
        lock_i = 4'b0000;
        req    = 4'b1001;
        expect_xfer(3, 3'd4, 8'h33);
        cyc();
        req = 4'b0001;
        expect_xfer(0, 3'd1, 8'hA5);
        cyc();
        req = 4'b0000;
        cyc();
`endif

        cyc();
        cyc();
        chk("gnt_queue_drained", gnt_exp_q.size(), 32'd0);
        chk("wr_queue_drained",  wr_exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
